// File: rtl/conv_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
package conv_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } acc_state_t;

  localparam int unsigned IN_WIDTH_D  = 32;
  localparam int unsigned ACC_WIDTH_D = 40;
  localparam int unsigned CNT_WIDTH_D = 16;

  // Sign-extend the low from_w bits of val to 64 bits; callers truncate to the
  // accumulator width, so widths up to 64 are supported.
  function automatic logic [63:0] sext_to_acc(input logic [63:0] val,
                                              input int unsigned from_w);
    logic signed [63:0] tmp;
    int unsigned        sh;
    sh  = 64 - from_w;
    tmp = $signed(val << sh);
    return tmp >>> sh;
  endfunction

endpackage

// File: rtl/psum_add.sv
// Combinational signed adder for the accumulator path.
// Build option: define PSUM_ACC_SAT_EN to clamp results instead of wrapping.
module psum_add #(
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o
);

  logic [ACC_WIDTH-1:0] raw_sum;

  assign raw_sum = a_i + b_i;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] MaxVal = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MinVal = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic ovf;

  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) &&
               (raw_sum[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);

  // Clamp toward the operands' sign on overflow.
  always_comb begin
    sum_o = raw_sum;
    if (ovf) begin
      sum_o = a_i[ACC_WIDTH-1] ? MinVal : MaxVal;
    end
  end
`else
  // Plain modulo-2^ACC_WIDTH addition.
  always_comb begin
    sum_o = raw_sum;
  end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_len partial sums per output pixel and streams cfg_num_out
// pixels to writeback over valid/ready, then pulses done.
// Build option: PSUM_ACC_SAT_EN selects saturating instead of wrapping adds.
module psum_accumulator
  import conv_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_D,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_D,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [CNT_WIDTH-1:0] cfg_num_out,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  acc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pix_q, pix_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic [ACC_WIDTH-1:0] in_sext;
  logic [ACC_WIDTH-1:0] add_a;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 beat_fire;
  logic                 last_beat;
  logic                 last_pix;
  logic                 out_fire;

  assign in_sext   = ACC_WIDTH'(sext_to_acc(64'(in_data), IN_WIDTH));
  // First beat of a pixel starts from zero so the sum equals the input.
  assign add_a     = (beat_q == '0) ? '0 : acc_q;
  assign in_ready  = (state_q == StAccum) && !(out_valid_q && !out_ready);
  assign beat_fire = in_valid && in_ready;
  assign last_beat = (beat_q == len_q - 1'b1);
  assign last_pix  = (pix_q == num_q - 1'b1);
  assign out_fire  = out_valid_q && out_ready;

  psum_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_psum_add (
    .a_i   (add_a),
    .b_i   (in_sext),
    .sum_o (add_sum)
  );

  // Next-state logic for the job FSM, counters and output holding register.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    beat_d      = beat_q;
    pix_d       = pix_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
          num_d   = (cfg_num_out == '0) ? CNT_WIDTH'(1) : cfg_num_out;
          beat_d  = '0;
          pix_d   = '0;
          acc_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (beat_fire) begin
          if (last_beat) begin
            // A new result may load in the same cycle the old one drains.
            out_data_d  = add_sum;
            out_valid_d = 1'b1;
            beat_d      = '0;
            pix_d       = pix_q + 1'b1;
            if (last_pix) begin
              state_d = StDrain;
            end
          end else begin
            acc_d  = add_sum;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      num_q       <= '0;
      beat_q      <= '0;
      pix_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      pix_q       <= pix_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed, table-driven bench for psum_accumulator.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_num_out;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  // Narrow-accumulator instance for the overflow cases.
  logic        b_start;
  logic [15:0] b_cfg_len;
  logic [15:0] b_cfg_num_out;
  logic        b_in_valid;
  logic [31:0] b_in_data;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [31:0] b_out_data;
  logic        b_busy;
  logic        b_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [39:0] got_q[$];
  int          got_cyc[$];

  always #5 clk = ~clk;

  psum_accumulator #(
    .IN_WIDTH  (32),
    .ACC_WIDTH (40),
    .CNT_WIDTH (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_num_out (cfg_num_out),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  psum_accumulator #(
    .IN_WIDTH  (32),
    .ACC_WIDTH (32),
    .CNT_WIDTH (16)
  ) u_dut32 (
    .clk         (clk),
    .rst         (rst),
    .start       (b_start),
    .cfg_len     (b_cfg_len),
    .cfg_num_out (b_cfg_num_out),
    .in_valid    (b_in_valid),
    .in_data     (b_in_data),
    .in_ready    (b_in_ready),
    .out_valid   (b_out_valid),
    .out_data    (b_out_data),
    .out_ready   (1'b1),
    .busy        (b_busy),
    .done        (b_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and done pulses, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int num);
    start       = 1'b1;
    cfg_len     = 16'(len);
    cfg_num_out = 16'(num);
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic send_beat(input logic [31:0] d);
    int   n;
    logic ok;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    check("beat_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int base, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic b_run(input int len, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input string name, input logic [31:0] exp);
    logic [31:0] dq[$];
    dq = '{d0, d1, d2};
    b_start       = 1'b1;
    b_cfg_len     = 16'(len);
    b_cfg_num_out = 16'd1;
    tick();
    b_start    = 1'b0;
    b_in_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      b_in_data = dq[i];
      tick();
    end
    b_in_valid = 1'b0;
    check({name, "_valid"}, 64'(b_out_valid), 64'd1);
    check(name, 64'(b_out_data), 64'(exp));
    tick();
    tick();
    check({name, "_idle"}, 64'(b_busy), 64'd0);
  endtask

  typedef struct {
    int           len;
    logic [127:0] d;
    logic [39:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int len, input logic [127:0] d, input logic [39:0] exp);
    vec_t v;
    v.len = len;
    v.d   = d;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    int          base;
    int          n;
    logic [127:0] sh;

    rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_num_out = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_cfg_len = '0; b_cfg_num_out = '0; b_in_valid = 1'b0; b_in_data = '0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    tick();

    // Single-pixel jobs; beat 0 sits in the low word of d.
    add_vec(4, {32'd4, 32'd3, 32'd2, 32'd1}, 40'd10);
    add_vec(3, {32'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB}, 40'hFF_FFFF_FFFC);
    add_vec(1, {96'd0, 32'd7}, 40'd7);
    add_vec(4, {4{32'h7FFF_FFFF}}, 40'h01_FFFF_FFFC);
    add_vec(2, {64'd0, 32'h8000_0000, 32'h8000_0000}, 40'hFF_0000_0000);
    add_vec(4, {32'hFFFF_FFCD, 32'd50, 32'hFFFF_FF9C, 32'd100}, 40'hFF_FFFF_FFFF);

    foreach (vecs[k]) begin
      start_job(vecs[k].len, 1);
      for (int i = 0; i < vecs[k].len; i++) begin
        sh = vecs[k].d >> (32 * i);
        send_beat(sh[31:0]);
      end
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_data", k), 64'(out_data), 64'(vecs[k].exp));
      check($sformatf("vec%0d_busy_drain", k), 64'(busy), 64'd1);
      tick();
      check($sformatf("vec%0d_done", k), 64'(done), 64'd1);
      check($sformatf("vec%0d_busy_off", k), 64'(busy), 64'd0);
      check($sformatf("vec%0d_valid_off", k), 64'(out_valid), 64'd0);
      tick();
      check($sformatf("vec%0d_done_pulse", k), 64'(done), 64'd0);
    end

    // Backpressure: hold out_ready low for 5 cycles after the first result.
    got_q.delete();
    got_cyc.delete();
    base      = done_cnt;
    out_ready = 1'b0;
    start_job(2, 3);
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          send_beat(32'd5);
          send_beat(32'hFFFF_FFF9);
        end
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          tick();
          n++;
        end
        check("bp_first_valid", 64'(out_valid), 64'd1);
        for (int h = 0; h < 5; h++) begin
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_data_stable", 64'(out_data), 64'h00_00FF_FFFF_FFFE);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_done(base, "bp_done_once");
    check("bp_count", 64'(got_q.size()), 64'd3);
    foreach (got_q[i]) check("bp_value", 64'(got_q[i]), 64'h00_00FF_FFFF_FFFE);

    // Full throughput: one pixel per cycle with len 1.
    tick();
    got_q.delete();
    got_cyc.delete();
    base = done_cnt;
    start_job(1, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(i);
      @(negedge clk);
      check("tp_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    wait_done(base, "tp_done_once");
    check("tp_count", 64'(got_q.size()), 64'd8);
    foreach (got_q[i]) begin
      check("tp_value", 64'(got_q[i]), 64'(i));
      check("tp_back_to_back", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end

    // Zero configuration and a start pulse ignored while busy.
    tick();
    got_q.delete();
    base = done_cnt;
    start_job(0, 0);
    start_job(5, 5);
    check("zc_busy", 64'(busy), 64'd1);
    send_beat(32'hFFFF_FFFD);
    in_valid = 1'b0;
    wait_done(base, "zc_done_once");
    tick();
    tick();
    tick();
    check("zc_idle_after", 64'(busy), 64'd0);
    check("zc_done_count", 64'(done_cnt - base), 64'd1);
    check("zc_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("zc_value", 64'(got_q[0]), 64'h00_00FF_FFFF_FFFD);

    // Overflow on the 32-bit accumulator.
`ifdef PSUM_ACC_SAT_EN
    b_run(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, "ovf_pos", 32'h7FFF_FFFF);
    b_run(2, 32'h8000_0000, 32'h8000_0000, 32'd0, "ovf_neg", 32'h8000_0000);
    b_run(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_recover", 32'h7FFF_FFFE);
`else
    b_run(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, "ovf_pos", 32'hFFFF_FFFE);
    b_run(2, 32'h8000_0000, 32'h8000_0000, 32'd0, "ovf_neg", 32'h0000_0000);
    b_run(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_recover", 32'hFFFF_FFFD);
`endif

    // Reset in the middle of a job.
    got_q.delete();
    start_job(4, 1);
    send_beat(32'd1);
    send_beat(32'd1);
    in_valid = 1'b0;
    base = done_cnt;
    rst  = 1'b0;
    tick();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("mid_rst_no_done", 64'(done_cnt - base), 64'd0);
    check("mid_rst_no_output", 64'(got_q.size()), 64'd0);
    start_job(4, 1);
    for (int i = 0; i < 4; i++) send_beat(32'd1);
    in_valid = 1'b0;
    check("mid_rst_new_data", 64'(out_data), 64'd4);
    wait_done(base, "mid_rst_new_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
